// File: rtl/traffic_light_ctrl.sv
// Two-road intersection sequencer with pedestrian walk and night blink.
// Time advances only on the 1-cycle tick enable; lamps are decoded from state.
module traffic_light_ctrl #(
    parameter int CW       = 8,
    parameter int T_MAIN_G = 20,
    parameter int T_SIDE_G = 10,
    parameter int T_YEL    = 3,
    parameter int T_ALLRED = 1,
    parameter int T_PED    = 5
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          tick,
    input  logic          ped_req,
    input  logic          night,
    output logic [2:0]    main_rgy,
    output logic [2:0]    side_rgy,
    output logic          ped_walk,
    output logic          ped_pend,
    output logic [CW-1:0] remain,
    output logic [2:0]    state
);

    localparam logic [2:0] S_MG  = 3'd0;
    localparam logic [2:0] S_MY  = 3'd1;
    localparam logic [2:0] S_AR1 = 3'd2;
    localparam logic [2:0] S_SG  = 3'd3;
    localparam logic [2:0] S_SY  = 3'd4;
    localparam logic [2:0] S_AR2 = 3'd5;
    localparam logic [2:0] S_BLK = 3'd6;

    localparam logic [CW-1:0] C_MG  = CW'(T_MAIN_G);
    localparam logic [CW-1:0] C_SG  = CW'(T_SIDE_G);
    localparam logic [CW-1:0] C_YEL = CW'(T_YEL);
    localparam logic [CW-1:0] C_AR  = CW'(T_ALLRED);
    localparam logic [CW-1:0] C_PED = CW'(T_PED);
    localparam logic [CW-1:0] C_ONE = CW'(1);

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;
    localparam logic [2:0] L_OFF = 3'b000;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          blink_q, blink_d;

    // Night wins over expiry and pedestrian shortening within one tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blink_d = blink_q;
        if (tick) begin
            if (state_q == S_BLK) begin
                if (night) begin
                    blink_d = ~blink_q;
                end else begin
                    state_d = S_AR2;
                    cnt_d   = C_AR;
                    blink_d = 1'b0;
                end
            end else if (night) begin
                state_d = S_BLK;
                blink_d = 1'b1;
            end else if (state_q == S_MG && pend_q && cnt_q > C_PED) begin
                cnt_d = C_PED;
            end else if (cnt_q == C_ONE) begin
                case (state_q)
                    S_MG:    begin state_d = S_MY;  cnt_d = C_YEL; end
                    S_MY:    begin state_d = S_AR1; cnt_d = C_AR;  end
                    S_AR1:   begin state_d = S_SG;  cnt_d = C_SG;  end
                    S_SG:    begin state_d = S_SY;  cnt_d = C_YEL; end
                    S_SY:    begin state_d = S_AR2; cnt_d = C_AR;  end
                    S_AR2:   begin state_d = S_MG;  cnt_d = C_MG;  end
                    default: begin state_d = S_AR2; cnt_d = C_AR;  end
                endcase
            end else begin
                cnt_d = cnt_q - C_ONE;
            end
        end
    end

    always_comb begin
        pend_d = pend_q;
        if (ped_req && state_q != S_SG) begin
            pend_d = 1'b1;
        end else if (state_d == S_SG && state_q != S_SG) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_AR2;
            cnt_q   <= C_AR;
            pend_q  <= 1'b0;
            blink_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            blink_q <= blink_d;
        end
    end

    always_comb begin
        main_rgy = L_RED;
        side_rgy = L_RED;
        ped_walk = 1'b0;
        remain   = cnt_q;
        unique case (1'b1)
            state_q == S_MG: main_rgy = L_GRN;
            state_q == S_MY: main_rgy = L_YEL;
            state_q == S_SG: begin
                side_rgy = L_GRN;
                ped_walk = 1'b1;
            end
            state_q == S_SY: side_rgy = L_YEL;
            state_q == S_BLK: begin
                main_rgy = blink_q ? L_YEL : L_OFF;
                side_rgy = blink_q ? L_RED : L_OFF;
                remain   = '0;
            end
            default: ;
        endcase
    end

    assign ped_pend = pend_q;
    assign state    = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: phase sequence, pedestrian,
// night blink and mid-phase reset, with a continuous lamp safety monitor.
module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       tick;
    logic       ped_req;
    logic       night;
    logic [2:0] main_rgy;
    logic [2:0] side_rgy;
    logic       ped_walk;
    logic       ped_pend;
    logic [7:0] remain;
    logic [2:0] state;

    int tests = 0;
    int failed = 0;
    int viol = 0;

    traffic_light_ctrl dut (
        .clk(clk), .rstn(rstn), .tick(tick), .ped_req(ped_req),
        .night(night), .main_rgy(main_rgy), .side_rgy(side_rgy),
        .ped_walk(ped_walk), .ped_pend(ped_pend), .remain(remain),
        .state(state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if ((main_rgy[1:0] != 2'b00 && side_rgy[1:0] != 2'b00) ||
                (ped_walk === 1'b1 && state !== 3'd3)) begin
                viol++;
                $display("FAIL safety: main=%b side=%b walk=%b state=%0d",
                         main_rgy, side_rgy, ped_walk, state);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic tick1();
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick1();
    endtask

    task automatic pulse_ped();
        @(negedge clk); ped_req = 1'b1;
        @(negedge clk); ped_req = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; tick = 1'b0; ped_req = 1'b0; night = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (state !== 3'd5 || remain !== 8'd1) begin
            failed++;
            $display("FAIL reset_hold: state=%0d remain=%0d want 5/1",
                     state, remain);
        end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (main_rgy !== 3'b100 || side_rgy !== 3'b100 ||
            ped_walk !== 1'b0 || ped_pend !== 1'b0) begin
            failed++;
            $display("FAIL reset_lamps: main=%b side=%b walk=%b pend=%b",
                     main_rgy, side_rgy, ped_walk, ped_pend);
        end
        tests++;
        if (state !== 3'd5 || remain !== 8'd1) begin
            failed++;
            $display("FAIL reset_rel: state=%0d remain=%0d want 5/1",
                     state, remain);
        end
    endtask

    task automatic test_normal_cycle();
        int         st[6]  = '{0, 1, 2, 3, 4, 5};
        int         dur[6] = '{20, 3, 1, 10, 3, 1};
        logic [2:0] mn[6]  = '{3'b001, 3'b010, 3'b100,
                               3'b100, 3'b100, 3'b100};
        logic [2:0] sd[6]  = '{3'b100, 3'b100, 3'b100,
                               3'b001, 3'b010, 3'b100};
        tick1();
        for (int p = 0; p < 6; p++) begin
            for (int k = dur[p]; k >= 1; k--) begin
                tests++;
                if (state !== st[p][2:0] || remain !== k[7:0]) begin
                    failed++;
                    $display("FAIL cycle_cnt: state=%0d remain=%0d want %0d/%0d",
                             state, remain, st[p], k);
                end
                tests++;
                if (main_rgy !== mn[p] || side_rgy !== sd[p] ||
                    ped_walk !== (p == 3)) begin
                    failed++;
                    $display("FAIL cycle_lamp: st=%0d main=%b side=%b walk=%b want %b/%b",
                             st[p], main_rgy, side_rgy, ped_walk, mn[p], sd[p]);
                end
                tick1();
            end
        end
        tests++;
        if (state !== 3'd0 || remain !== 8'd20) begin
            failed++;
            $display("FAIL cycle_wrap: state=%0d remain=%0d want 0/20",
                     state, remain);
        end
    endtask

    task automatic test_ped_shorten();
        ticks(5);
        pulse_ped();
        tests++;
        if (ped_pend !== 1'b1 || remain !== 8'd15) begin
            failed++;
            $display("FAIL ped_latch: pend=%b remain=%0d want 1/15",
                     ped_pend, remain);
        end
        tick1();
        tests++;
        if (state !== 3'd0 || remain !== 8'd5) begin
            failed++;
            $display("FAIL ped_short: state=%0d remain=%0d want 0/5",
                     state, remain);
        end
        ticks(4);
        tests++;
        if (state !== 3'd0 || remain !== 8'd1) begin
            failed++;
            $display("FAIL ped_last: state=%0d remain=%0d want 0/1",
                     state, remain);
        end
        tick1();
        tests++;
        if (state !== 3'd1 || remain !== 8'd3) begin
            failed++;
            $display("FAIL ped_my: state=%0d remain=%0d want 1/3",
                     state, remain);
        end
        ticks(3);
        tests++;
        if (state !== 3'd2 || ped_pend !== 1'b1) begin
            failed++;
            $display("FAIL ped_ar1: state=%0d pend=%b want 2/1",
                     state, ped_pend);
        end
        tick1();
        tests++;
        if (state !== 3'd3 || ped_pend !== 1'b0 || ped_walk !== 1'b1) begin
            failed++;
            $display("FAIL ped_sg: state=%0d pend=%b walk=%b want 3/0/1",
                     state, ped_pend, ped_walk);
        end
    endtask

    task automatic test_ped_no_extend();
        pulse_ped();
        tests++;
        if (ped_pend !== 1'b0) begin
            failed++;
            $display("FAIL ped_in_sg: pend=%b want 0", ped_pend);
        end
        ticks(9);
        tests++;
        if (state !== 3'd3 || ped_walk !== 1'b1 || remain !== 8'd1) begin
            failed++;
            $display("FAIL walk_len: state=%0d walk=%b remain=%0d want 3/1/1",
                     state, ped_walk, remain);
        end
        ticks(1 + 3 + 1 + 17);
        tests++;
        if (state !== 3'd0 || remain !== 8'd3) begin
            failed++;
            $display("FAIL mg_at3: state=%0d remain=%0d want 0/3",
                     state, remain);
        end
        pulse_ped();
        tick1();
        tests++;
        if (remain !== 8'd2 || ped_pend !== 1'b1) begin
            failed++;
            $display("FAIL no_ext2: remain=%0d pend=%b want 2/1",
                     remain, ped_pend);
        end
        tick1();
        tick1();
        tests++;
        if (state !== 3'd1) begin
            failed++;
            $display("FAIL no_ext_my: state=%0d want 1", state);
        end
        ticks(4);
        tests++;
        if (state !== 3'd3 || remain !== 8'd10 || ped_pend !== 1'b0) begin
            failed++;
            $display("FAIL no_ext_sg: state=%0d remain=%0d pend=%b want 3/10/0",
                     state, remain, ped_pend);
        end
    endtask

    task automatic test_night();
        ticks(3);
        tests++;
        if (state !== 3'd3 || remain !== 8'd7) begin
            failed++;
            $display("FAIL night_pre: state=%0d remain=%0d want 3/7",
                     state, remain);
        end
        night = 1'b1;
        tick1();
        tests++;
        if (state !== 3'd6 || main_rgy !== 3'b010 || side_rgy !== 3'b100 ||
            ped_walk !== 1'b0 || remain !== 8'd0) begin
            failed++;
            $display("FAIL blk_on: state=%0d main=%b side=%b walk=%b rem=%0d",
                     state, main_rgy, side_rgy, ped_walk, remain);
        end
        tick1();
        tests++;
        if (state !== 3'd6 || main_rgy !== 3'b000 || side_rgy !== 3'b000) begin
            failed++;
            $display("FAIL blk_off: state=%0d main=%b side=%b want 6/000/000",
                     state, main_rgy, side_rgy);
        end
        tick1();
        tests++;
        if (main_rgy !== 3'b010 || side_rgy !== 3'b100) begin
            failed++;
            $display("FAIL blk_on2: main=%b side=%b want 010/100",
                     main_rgy, side_rgy);
        end
        night = 1'b0;
        tick1();
        tests++;
        if (state !== 3'd5 || remain !== 8'd1 ||
            main_rgy !== 3'b100 || side_rgy !== 3'b100) begin
            failed++;
            $display("FAIL blk_exit: state=%0d remain=%0d main=%b side=%b",
                     state, remain, main_rgy, side_rgy);
        end
        tick1();
        tests++;
        if (state !== 3'd0 || remain !== 8'd20) begin
            failed++;
            $display("FAIL blk_mg: state=%0d remain=%0d want 0/20",
                     state, remain);
        end
    endtask

    task automatic test_night_ped_same_tick();
        ticks(8);
        @(negedge clk);
        ped_req = 1'b1; night = 1'b1; tick = 1'b1;
        @(negedge clk);
        ped_req = 1'b0; night = 1'b0; tick = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (state !== 3'd6 || ped_pend !== 1'b1) begin
            failed++;
            $display("FAIL np_blk: state=%0d pend=%b want 6/1",
                     state, ped_pend);
        end
        tick1();
        tick1();
        tests++;
        if (state !== 3'd0 || remain !== 8'd20) begin
            failed++;
            $display("FAIL np_mg: state=%0d remain=%0d want 0/20",
                     state, remain);
        end
        tick1();
        tests++;
        if (remain !== 8'd5) begin
            failed++;
            $display("FAIL np_short: remain=%0d want 5", remain);
        end
    endtask

    task automatic test_reset_mid_phase();
        ticks(5 + 3 + 1 + 10 + 1);
        tests++;
        if (state !== 3'd4 || remain !== 8'd2) begin
            failed++;
            $display("FAIL sy_pre: state=%0d remain=%0d want 4/2",
                     state, remain);
        end
        @(negedge clk);
        rstn = 1'b0;
        #1;
        tests++;
        if (state !== 3'd5 || remain !== 8'd1) begin
            failed++;
            $display("FAIL async_rst: state=%0d remain=%0d want 5/1",
                     state, remain);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (state !== 3'd5 || remain !== 8'd1 || main_rgy !== 3'b100 ||
            side_rgy !== 3'b100 || ped_pend !== 1'b0) begin
            failed++;
            $display("FAIL rst_rel: state=%0d rem=%0d main=%b side=%b pend=%b",
                     state, remain, main_rgy, side_rgy, ped_pend);
        end
        tick1();
        tests++;
        if (state !== 3'd0 || remain !== 8'd20) begin
            failed++;
            $display("FAIL rst_mg: state=%0d remain=%0d want 0/20",
                     state, remain);
        end
    endtask

    task automatic test_safety();
        tests++;
        if (viol !== 0) begin
            failed++;
            $display("FAIL safety_total: violations=%0d want 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_normal_cycle();
        test_ped_shorten();
        test_ped_no_extend();
        test_night();
        test_night_ped_same_tick();
        test_reset_mid_phase();
        test_safety();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
